// File: rtl/decode_pkg.sv
// Shared types and encodings for the decode stage.
// Defining FPU_DECODE_EN adds the floating-point control fields and opcodes.
package decode_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OP_STORE_FP = 7'b0100111;
  localparam logic [6:0] OP_FP       = 7'b1010011;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_SH = 3'b100;
  localparam logic [2:0] IMM_U  = 3'b101;

  localparam logic [2:0] RES_ALU = 3'b000;
  localparam logic [2:0] RES_MEM = 3'b001;
  localparam logic [2:0] RES_PC4 = 3'b010;
  localparam logic [2:0] RES_CSR = 3'b011;
  localparam logic [2:0] RES_IMM = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PC    = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       c_reg_write;
`ifdef FPU_DECODE_EN
    logic       fp_reg_write;
    logic       fp_src;
`endif
  } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
import decode_pkg::*;

interface decode_stage_if #(parameter int XLEN = 32) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  ctrl_t           out_ctrl;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_instr, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_instr, out_pc, out_illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 to control-bundle decoder; unknown opcodes flag illegal.
// FP opcodes decode only when FPU_DECODE_EN is defined.
import decode_pkg::*;

module ctrl_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_PC;
      end
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMM;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_SUB;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        // shifts carry a shamt field rather than a sign-extended immediate
        ctrl.imm_src   = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SH : IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_op     = ALUOP_FUNCT;
        ctrl.jump       = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      OP_SYSTEM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.result_src  = RES_CSR;
        ctrl.c_reg_write = 1'b1;
      end
`ifdef FPU_DECODE_EN
      OP_LOAD_FP: begin
        ctrl.alu_src      = 1'b1;
        ctrl.result_src   = RES_MEM;
        ctrl.fp_reg_write = 1'b1;
      end
      OP_STORE_FP: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.fp_src    = 1'b1;
      end
      OP_FP: begin
        ctrl.fp_reg_write = 1'b1;
        ctrl.alu_op       = ALUOP_ADD;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes at push and buffers results in a DEPTH-entry FIFO.
// Optional FP decode enabled by defining FPU_DECODE_EN.
import decode_pkg::*;

module decode_stage #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  decode_stage_if.slave        dif,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam int AW = $clog2(DEPTH);

  ctrl_t           mem_ctrl    [DEPTH];
  logic            mem_illegal [DEPTH];
  logic [XLEN-1:0] mem_instr   [DEPTH];
  logic [XLEN-1:0] mem_pc      [DEPTH];

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  ctrl_t       dec_ctrl;
  logic        dec_illegal;

  ctrl_decode u_ctrl_decode (
    .opcode  (dif.in_instr[6:0]),
    .funct3  (dif.in_instr[14:12]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign dif.in_ready = !full || pop;
  assign pop  = !empty && dif.out_ready;
  assign push = dif.in_valid && dif.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ctrl[wr_ptr[AW-1:0]]    <= dec_ctrl;
      mem_illegal[wr_ptr[AW-1:0]] <= dec_illegal;
      mem_instr[wr_ptr[AW-1:0]]   <= dif.in_instr;
      mem_pc[wr_ptr[AW-1:0]]      <= dif.in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ill_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && dec_illegal && ill_count != '1) ill_count <= ill_count + 1'b1;
    end
  end

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign dif.out_valid   = !empty;
  assign dif.out_ctrl    = empty ? '0   : mem_ctrl[rd_ptr[AW-1:0]];
  assign dif.out_illegal = empty ? 1'b0 : mem_illegal[rd_ptr[AW-1:0]];
  assign dif.out_instr   = empty ? '0   : mem_instr[rd_ptr[AW-1:0]];
  assign dif.out_pc      = empty ? '0   : mem_pc[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
// Honours FPU_DECODE_EN when defined.
import decode_pkg::*;

module tb_decode_stage;

  localparam int DEPTH = 2;
  localparam int CW    = $bits(ctrl_t);

  localparam logic [13:0] LIT_LW   = 14'b1_000_1_0_001_0_00_0_0;
  localparam logic [13:0] LIT_ADDI = 14'b1_000_1_0_000_0_10_0_0;
  localparam logic [13:0] LIT_SLLI = 14'b1_100_1_0_000_0_10_0_0;
  localparam logic [13:0] LIT_LUI  = 14'b1_101_0_0_100_0_00_0_0;
  localparam logic [13:0] LIT_B    = 14'b0_010_0_0_000_1_01_0_0;
  localparam logic [13:0] LIT_FLW  = 14'b0_000_1_0_001_0_00_0_0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] ill_count;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  decode_stage_if #(.XLEN(32)) dif ();

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ILL_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .dif       (dif),
    .ill_count (ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    bit            ill;
    logic [31:0]   instr;
    logic [31:0]   pc;
  } exp_t;

  exp_t     exp_q[$];
  int       m_ill = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic void model_dec(input logic [31:0] ins, output logic [CW-1:0] c, output bit ill);
    logic [13:0] b;
`ifdef FPU_DECODE_EN
    logic [1:0] f;
    f = 2'b00;
`endif
    b = '0;
    ill = 1'b0;
    case (ins[6:0])
      7'b0000011: b = 14'b1_000_1_0_001_0_00_0_0;
      7'b0100011: b = 14'b0_001_1_1_000_0_00_0_0;
      7'b0010111: b = 14'b1_101_1_0_000_0_11_0_0;
      7'b0110011: b = 14'b1_000_0_0_000_0_10_0_0;
      7'b0110111: b = 14'b1_101_0_0_100_0_00_0_0;
      7'b1100011: b = 14'b0_010_0_0_000_1_01_0_0;
      7'b0010011: b = (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ?
                      14'b1_100_1_0_000_0_10_0_0 : 14'b1_000_1_0_000_0_10_0_0;
      7'b1100111: b = 14'b1_000_1_0_010_0_10_1_0;
      7'b1101111: b = 14'b1_011_0_0_010_0_00_1_0;
      7'b1110011: b = 14'b1_000_0_0_011_0_00_0_1;
`ifdef FPU_DECODE_EN
      7'b0000111: begin b = 14'b0_000_1_0_001_0_00_0_0; f = 2'b10; end
      7'b0100111: begin b = 14'b0_001_1_1_000_0_00_0_0; f = 2'b01; end
      7'b1010011: f = 2'b10;
`endif
      default: ill = 1'b1;
    endcase
`ifdef FPU_DECODE_EN
    c = {b, f};
`else
    c = b;
`endif
  endfunction

  function automatic logic [13:0] ctrl_base();
    logic [CW-1:0] t;
    t = dif.out_ctrl;
    return t[CW-1 -: 14];
  endfunction

  // Compare against the model every cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    int  n;
    bit  m_ready;
    exp_t e;
    n = exp_q.size();
    m_ready = (n < DEPTH) || (n > 0 && dif.out_ready);
    if (chk_en) begin
      chk("out_valid", 64'(dif.out_valid), 64'(n > 0));
      chk("in_ready", 64'(dif.in_ready), 64'(m_ready));
      chk("ill_count", 64'(ill_count), 64'(m_ill));
      if (n > 0) begin
        chk("out_ctrl", 64'(dif.out_ctrl), 64'(exp_q[0].ctrl));
        chk("out_illegal", 64'(dif.out_illegal), 64'(exp_q[0].ill));
        chk("out_instr", 64'(dif.out_instr), 64'(exp_q[0].instr));
        chk("out_pc", 64'(dif.out_pc), 64'(exp_q[0].pc));
      end else begin
        chk("empty_ctrl", 64'(dif.out_ctrl), 64'd0);
        chk("empty_instr_pc", {dif.out_instr, dif.out_pc}, 64'd0);
      end
    end
    if (rst) begin
      exp_q.delete();
      m_ill = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (n > 0 && dif.out_ready) void'(exp_q.pop_front());
      if (dif.in_valid && m_ready) begin
        model_dec(dif.in_instr, e.ctrl, e.ill);
        e.instr = dif.in_instr;
        e.pc    = dif.in_pc;
        exp_q.push_back(e);
        if (e.ill && m_ill != 255) m_ill++;
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] p,
                       input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    dif.in_valid  = v;
    dif.in_instr  = ins;
    dif.in_pc     = p;
    dif.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] misc [4];
`ifdef FPU_DECODE_EN
    int ill_after_flw = 0;
`else
    int ill_after_flw = 1;
`endif
    misc[0] = 32'h00000097;
    misc[1] = 32'h000080E7;
    misc[2] = 32'h008000EF;
    misc[3] = 32'h30529073;

    dif.in_valid = 1'b0; dif.in_instr = '0; dif.in_pc = '0; dif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_valid", 64'(dif.out_valid), 64'd0);
    chk("reset_ready", 64'(dif.in_ready), 64'd1);
    chk("reset_ill", 64'(ill_count), 64'd0);

    drive(1, 32'h00002083, 32'h100, 1, 0);
    drive(1, 32'h00108093, 32'h104, 1, 0);
    @(negedge clk);
    chk("lw_ctrl", 64'(ctrl_base()), 64'(LIT_LW));
    chk("lw_pc", 64'(dif.out_pc), 64'h100);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("addi_ctrl", 64'(ctrl_base()), 64'(LIT_ADDI));
    chk("addi_pc", 64'(dif.out_pc), 64'h104);
    drive(0, 0, 0, 1, 0);

    drive(1, 32'h00109093, 32'h110, 1, 0);
    drive(1, 32'h000010B7, 32'h114, 1, 0);
    @(negedge clk);
    chk("slli_ctrl", 64'(ctrl_base()), 64'(LIT_SLLI));
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lui_ctrl", 64'(ctrl_base()), 64'(LIT_LUI));
    drive(0, 0, 0, 1, 0);

    // fill with execute stalled, then push and pop together while full
    drive(1, 32'h002081B3, 32'h200, 0, 0);
    drive(1, 32'h0020A023, 32'h204, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_ready", 64'(dif.in_ready), 64'd0);
    chk("full_head_pc", 64'(dif.out_pc), 64'h200);
    drive(1, 32'h00208463, 32'h208, 1, 0);
    @(negedge clk);
    chk("full_pushpop_ready", 64'(dif.in_ready), 64'd1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("order_pc1", 64'(dif.out_pc), 64'h204);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("order_pc2", 64'(dif.out_pc), 64'h208);
    chk("b_ctrl", 64'(ctrl_base()), 64'(LIT_B));
    drive(0, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) drive(1, misc[i], 32'h240 + 32'(i * 4), 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    drive(1, 32'h00002087, 32'h300, 1, 0);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
`ifdef FPU_DECODE_EN
    chk("flw_ctrl", 64'(ctrl_base()), 64'(LIT_FLW));
    chk("flw_fp", 64'(dif.out_ctrl.fp_reg_write), 64'd1);
`else
    chk("flw_illegal", 64'(dif.out_illegal), 64'd1);
    chk("flw_ctrl_zero", 64'(dif.out_ctrl), 64'd0);
`endif
    chk("flw_ill_count", 64'(ill_count), 64'(ill_after_flw));
    drive(0, 0, 0, 1, 0);

    // flush while holding two entries; the flushed-cycle input is illegal and must not count
    drive(1, 32'h002081B3, 32'h400, 0, 0);
    drive(1, 32'h0020A023, 32'h404, 0, 0);
    drive(1, 32'h0000007F, 32'h408, 0, 1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("flush_valid", 64'(dif.out_valid), 64'd0);
    chk("flush_ill", 64'(ill_count), 64'(ill_after_flw));
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      drive(1, 32'h0000007F, 32'h1000 + 32'(i), 1, 0);
      if (i == 10) begin
        @(negedge clk);
        chk("ill_head_flag", 64'(dif.out_illegal), 64'd1);
        chk("ill_head_ctrl", 64'(dif.out_ctrl), 64'd0);
      end
    end
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("ill_saturate", 64'(ill_count), 64'd255);

    drive(1, 32'h00002083, 32'h500, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("midrst_valid", 64'(dif.out_valid), 64'd0);
    chk("midrst_ill", 64'(ill_count), 64'd0);
    chk("midrst_ready", 64'(dif.in_ready), 64'd1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
